// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage with IF/ID output register
//
// Purpose:
//   Owns the program counter and presents it to the instruction ROM as a
//   combinational byte address. The instruction word the ROM returns in the
//   same cycle is captured, together with its PC, into the IF/ID register.
//   Decode takes that register with a valid/ready handshake. A branch
//   redirect flushes the register and reloads the PC.
//
// Configuration:
//   IFETCH_BOUNDS_CHECK_EN - when defined, a fetch from a misaligned PC, or
//   from a word that does not lie entirely below MEM_BYTES, is refused. The
//   refusal raises the sticky fetch_fault output, and fetching stays stopped
//   until a redirect or a reset. When undefined, no range check is made and
//   fetch_fault is constant 0.
//
// Parameters:
//   ADDR_W     PC / ROM address width in bits
//   RESET_PC   word-aligned byte address loaded into the PC on reset
//   MEM_BYTES  ROM size in bytes (power of 2, > 4); used only by the bounds check
//
// Ports:
//   clk              clock; all state changes on the rising edge
//   reset_n          synchronous active-low reset
//   fetch_en         fetch permitted this cycle
//   redirect_valid   redirect request from branch resolution
//   redirect_target  new PC; the low two bits are ignored
//   imem_addr        ROM byte address, always equal to the PC
//   imem_instr       ROM data, returned combinationally in the same cycle
//   out_valid        IF/ID register holds an instruction
//   out_ready        decode accepts the IF/ID register this cycle
//   out_instr        captured instruction word
//   out_pc           PC of out_instr
//   fetch_fault      sticky out-of-bounds / misaligned fetch indication

module instr_fetch_unit #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                MEM_BYTES = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              fetch_en,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic              fetch_fault
);

`ifdef IFETCH_BOUNDS_CHECK_EN
   localparam bit BOUNDS_CHECK = 1'b1;
`else
   localparam bit BOUNDS_CHECK = 1'b0;
`endif

   // The bound is compared one bit wider than the PC. This keeps pc+3 from
   // wrapping back into range near the top of the address space.
   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

   logic [ADDR_W-1:0] pc;
   logic              fault_q;

   logic              accept;
   logic              slot_free;
   logic              fetch_attempt;
   logic              range_bad;
   logic              fetch_go;
   logic              fault_set;
   logic [ADDR_W:0]   pc_last_byte;
   logic [ADDR_W-1:0] target_aligned;

   assign imem_addr      = pc;
   assign fetch_fault    = fault_q;

   assign accept         = out_valid & out_ready;
   assign slot_free      = ~out_valid | out_ready;

   // The low two bits of the redirect target are masked to word alignment.
   // The mask is applied to the whole vector so that every bit of the port
   // is consumed.
   assign target_aligned = redirect_target & ~(ADDR_W'(3));

   // The last byte of the word at pc must be addressable.
   assign pc_last_byte   = {1'b0, pc} + (ADDR_W+1)'(3);

   // With the check compiled out, range_bad is a constant 0. The fault
   // register then can never set, so it reduces to a constant 0.
   assign range_bad      = BOUNDS_CHECK &&
                           ((pc_last_byte >= MEM_LIMIT) || (pc[1:0] != 2'b00));

   // A fetch attempt wants the slot; it either captures or faults.
   assign fetch_attempt  = fetch_en & slot_free & ~redirect_valid & ~fault_q;
   assign fetch_go       = fetch_attempt & ~range_bad;
   assign fault_set      = fetch_attempt &  range_bad;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc        <= RESET_PC;
         out_valid <= 1'b0;
         out_instr <= '0;
         out_pc    <= '0;
         fault_q   <= 1'b0;
      end else if (redirect_valid) begin
         // A redirect flushes whatever sits in IF/ID, even if decode is
         // accepting it this cycle. Decode is being redirected as well.
         pc        <= target_aligned;
         out_valid <= 1'b0;
         fault_q   <= 1'b0;
      end else if (fetch_go) begin
         out_instr <= imem_instr;
         out_pc    <= pc;
         out_valid <= 1'b1;
         pc        <= pc + ADDR_W'(4);
      end else begin
         // Hold: the PC stays put. A drained word leaves its instr/pc
         // visible, but it is marked invalid.
         if (accept) begin
            out_valid <= 1'b0;
         end
         if (fault_set) begin
            fault_q <= 1'b1;
         end
      end
   end

endmodule
